// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU multiply/divide unit.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } muldiv_state_t;

  localparam int MULDIV_ITER = 32;

  function automatic logic op_is_signed(input muldiv_op_t o);
    return ~o[0];
  endfunction

  function automatic logic op_is_div(input muldiv_op_t o);
    return o[1];
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One combinational iteration: shift-add multiply (LSB first) or restoring
// divide (MSB first), both on a 64-bit {upper, lower} accumulator.
module mips_cpu_muldiv_step (
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  input  logic        is_div,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] rem;
  logic [32:0] diff;

  always_comb begin
    sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? operand : 32'd0)};
    rem  = {acc[63:32], acc[31]};
    diff = rem - {1'b0, operand};
    if (is_div) begin
      // Partial remainder fits if it overflowed 32 bits or the subtract did not borrow.
      if (rem[32] || !diff[32])
        acc_next = {diff[31:0], acc[30:0], 1'b1};
      else
        acc_next = {rem[31:0], acc[30:0], 1'b0};
    end else begin
      acc_next = {sum, acc[31:1]};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO writes.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational multiply path.
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t state;
  muldiv_op_t    op_reg;
  muldiv_op_t    op_in;
  logic [4:0]    cnt;
  logic [31:0]   mag_b;
  logic          neg_res;
  logic          neg_rem;
  logic [63:0]   acc;
  logic [63:0]   acc_next;
`ifdef MULDIV_FAST_MULT_EN
  logic [31:0]   mag_a;
`endif

  logic          a_neg, b_neg, div0, skip_run;
  logic [31:0]   a_mag, b_mag;
  logic [63:0]   prod, prod_fix;
  logic [31:0]   quo_fix, rem_fix;

  always_comb begin
    op_in = muldiv_op_t'(op);
    a_neg = op_is_signed(op_in) & a[31];
    b_neg = op_is_signed(op_in) & b[31];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    div0  = op_is_div(op_in) && (b == 32'd0);
`ifdef MULDIV_FAST_MULT_EN
    skip_run = div0 || !op_is_div(op_in);
    prod     = {32'd0, mag_a} * {32'd0, mag_b};
`else
    skip_run = div0;
    prod     = acc;
`endif
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -acc[31:0] : acc[31:0];
    rem_fix  = neg_rem ? -acc[63:32] : acc[63:32];
  end

  mips_cpu_muldiv_step u_step (
    .acc      (acc),
    .operand  (mag_b),
    .is_div   (op_is_div(op_reg)),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_reg  <= MULT;
      cnt     <= 5'd0;
      mag_b   <= 32'd0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc     <= 64'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef MULDIV_FAST_MULT_EN
      mag_a   <= 32'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_reg <= op_in;
            mag_b  <= b_mag;
            cnt    <= 5'd0;
            busy   <= 1'b1;
`ifdef MULDIV_FAST_MULT_EN
            mag_a  <= a_mag;
`endif
            // Divide by zero leaves HI=a, LO=0 with sign correction disabled.
            if (div0) begin
              acc     <= {a, 32'd0};
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
            end else begin
              acc     <= {32'd0, a_mag};
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
            end
            state <= skip_run ? FIX : RUN;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(MULDIV_ITER - 1))
            state <= FIX;
        end
        FIX: begin
          if (op_is_div(op_reg)) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench: directed literal cases plus randomized traffic compared
// every cycle against a latency-countdown arithmetic model.
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_FAST_MULT_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif

  // Architectural result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint unsigned ux = {32'd0, x};
    longint unsigned uy = {32'd0, y};
    longint q, r;
    case (o)
      2'b00: return 64'(sx * sy);
      2'b01: return ux * uy;
      default: begin
        if (y == 32'd0) return {x, 32'd0};
        if (o == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
          return {r[31:0], q[31:0]};
        end
        return {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] y);
    if (o[1] && y == 32'd0) return 1;
    if (!o[1]) return LAT_MUL;
    return 33;
  endfunction

  // Model: counts down cycles to completion, then publishes the pending result.
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [63:0] pend = 64'd0;
  int          m_left = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_hi <= 32'd0; m_lo <= 32'd0; m_left <= 0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_hi <= pend[63:32]; m_lo <= pend[31:0];
      end else begin
        m_done <= 1'b0;
        m_left <= m_left - 1;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        pend   <= ref_result(op, a, b);
        m_left <= ref_latency(op, b);
        m_busy <= 1'b1;
      end else begin
        if (mthi) m_hi <= wdata;
        if (mtlo) m_lo <= wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (busy !== m_busy || done !== m_done || hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t busy=%b exp %b done=%b exp %b hi=%h exp %h lo=%h exp %h",
                 $time, busy, m_busy, done, m_done, hi, m_hi, lo, m_lo);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat);
    int cyc;
    issue(o, x, y);
    wait_done(cyc);
    check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
    check({name, "_model_hi"}, m_hi, exp_hi);
    check({name, "_model_lo"}, m_lo, exp_lo);
    $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h after %0d cycles", name, o, x, y, hi, lo, cyc);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    reset = 1'b0;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_flags", {30'd0, busy, done}, 32'd0);

    run_check("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT_MUL);
    run_check("multu_b2b", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, LAT_MUL);
    run_check("div_m7d2",  2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_check("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_check("divu_by0",  2'b11, 32'd7, 32'd0, 32'd7, 32'd0, 1);
    run_check("div_intmin", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    run_check("multu_ffx2", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, LAT_MUL);

    // Start and MTHI while busy must both be ignored.
    @(negedge clk);
    issue(2'b11, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5; mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    check("busy_hi_held", hi, 32'h0000_0001);
    wait_done(cyc);
    check("ignored_start_hi", hi, 32'd2);
    check("ignored_start_lo", lo, 32'd14);

    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_both_hi", hi, 32'hCAFE_F00D);
    check("mt_both_lo", lo, 32'hCAFE_F00D);
    $display("txn mthi+mtlo wdata=cafef00d -> hi=%h lo=%h", hi, lo);

    // Start wins over a same-cycle MT write.
    mthi = 1'b1; wdata = 32'h55;
    run_check("start_over_mt", 2'b11, 32'd9, 32'd4, 32'd1, 32'd2, 33);
    mthi = 1'b0;

    // Asynchronous reset in the middle of a DIVU.
    @(negedge clk);
    issue(2'b11, 32'hDEAD_BEEF, 32'd3);
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_hi", hi, 32'd0);
    check("async_rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_check("after_reset", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);

    // Randomized traffic; the per-cycle compare does the checking.
    repeat (2500) begin
      start = ($urandom % 6) == 0;
      op    = 2'($urandom);
      a     = pick();
      b     = pick();
      mthi  = ($urandom % 4) == 0;
      mtlo  = ($urandom % 4) == 0;
      wdata = $urandom;
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_muldiv.md
# mips_cpu_muldiv

Multi-cycle multiply/divide unit owning the architectural HI/LO registers of the MIPS CPU core. It accepts MULT, MULTU, DIV and DIVU from the decode/execute stage, computes them iteratively over 32 steps, and holds the result in HI/LO for MFHI/MFLO. It also takes MTHI/MTLO writes. A busy flag lets the pipeline stall on HI/LO hazards.

## Interface
- `WIDTH`, 32: operand and HI/LO width; only 32 is supported.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request; sampled only while `busy`=0.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` input 32: rs operand, sampled with `start`.
- `b` input 32: rt operand, sampled with `start`.
- `mthi` input 1: write `wdata` to HI.
- `mtlo` input 1: write `wdata` to LO.
- `wdata` input 32: MTHI/MTLO data.
- `busy` output 1: operation in progress; the CPU stalls MFHI/MFLO/MTHI/MTLO/new start.
- `done` output 1: one-cycle pulse; HI/LO carry a new result.
- `hi` output 32: HI register (multiply high word / division remainder).
- `lo` output 32: LO register (multiply low word / division quotient).

## Operation
- States:
  - IDLE: wait for a request.
  - RUN: 32 iterations; a 5-bit counter runs 0..31.
  - FIX: apply sign correction, write HI/LO, pulse `done`.
- IDLE with `start`=1:
  - Latch `op`.
  - Latch operand magnitudes: two's-complement negation when signed and bit 31 is set; unsigned ops use raw values.
  - Latch the result sign flags.
  - Counter clears to 0 and the state moves to RUN.
- MULT/MULTU: shift-add over a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- DIV/DIVU: restoring division, one quotient bit per cycle, MSB first. Uses a 33-bit partial-remainder subtract.
- FIX sign correction:
  - Signed multiply: negate the 64-bit product if operand signs differ.
  - Signed divide: negate the quotient if signs differ; negate the remainder if `a` is negative.
- Divide by zero (`b`=0, DIV or DIVU): skip RUN, go IDLE→FIX. Result is HI=`a`, LO=0, with no sign correction.
- INT_MIN / -1 (DIV): LO=0x80000000, HI=0; no trap.
- `start` while `busy`=1: ignored.
- `mthi`/`mtlo` while `busy`=1: ignored.
- `mthi`/`mtlo` in IDLE with `start`=0: the write takes effect at the next edge. Both may assert together.
- `start` and `mthi`/`mtlo` in the same IDLE cycle: `start` wins and the MT write is dropped.
- Reset, including mid-operation: state goes to IDLE, counter to 0, `hi`=`lo`=0, `busy`=0, `done`=0.

## Timing
- Edge E0 samples `start`; `busy`=1 from E0 onward.
- RUN iterations occur at edges E1..E32. FIX writes HI/LO at E33.
- At E33 `done` rises for exactly one cycle and `busy` falls.
- Latency: 33 cycles from the start edge to result visibility.
- Divide by zero: FIX at E1, so `done`/result appear after E1.
- A new `start` is accepted in the same cycle `done` is high (back-to-back issue).
- `hi`/`lo` are registered outputs. They hold their old value throughout RUN and change only at FIX or on an MT write.

## Configuration
- `MULDIV_FAST_MULT_EN` defined: MULT/MULTU use a combinational 32x32 product.
  - The product is computed from the latched magnitudes.
  - The unit goes IDLE→FIX in one step: result after E1, `done` in the cycle after E1.
  - DIV/DIVU stay iterative.
- Undefined: all four ops are iterative, with 33-cycle latency.

## Structure
- `mips_cpu_pkg` holds:
  - the `muldiv_op_t` enum (MULT/MULTU/DIV/DIVU encodings above);
  - the `muldiv_state_t` enum (IDLE/RUN/FIX);
  - the `MULDIV_ITER` = 32 constant.
- Sub-module `mips_cpu_muldiv_step`: combinational single iteration.
  - Inputs: accumulator, operand and op class.
  - Outputs: next accumulator (shift-add) or next remainder/quotient (trial subtract).
  - The top level owns the FSM, counter, sign logic and HI/LO.

## Test plan
- Reset mid-RUN: assert `reset` at E10 of a DIVU → `busy`=0, `hi`=`lo`=0 immediately (asynchronous); next `start` proceeds normally.
- MULT: `a`=0xFFFFFFFD (-3), `b`=5 → after 33 cycles `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULTU with the same operands → `hi`=0x00000004, `lo`=0xFFFFFFF1.
- DIV: `a`=0xFFFFFFF9 (-7), `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100/7 → `lo`=14, `hi`=2.
- DIVU: `a`=7, `b`=0 → `done` after E1, `hi`=7, `lo`=0. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- `start` at E5 of a running op → ignored; result unchanged. `mthi` with 0x1234 while `busy` → HI unchanged. `mthi`+`mtlo` in IDLE → both registers updated next edge.
- `start` asserted during the `done` cycle → accepted; second result 33 cycles later. With `MULDIV_FAST_MULT_EN`: MULTU 0xFFFFFFFF×2 → `hi`=1, `lo`=0xFFFFFFFE after E1.
